// File: rtl/mii_rx_frame_buf.sv
// MII receive frame buffer: strips preamble/SFD, packs nibbles into bytes and
// ping-pongs between two DEPTH-byte banks so the consumer can read one frame
// while the next is captured.
module mii_rx_frame_buf #(
    parameter int DEPTH     = 64,
    parameter int AW        = 6,
    parameter int STRIP_PRE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_dv,
    input  logic [3:0]    rx_d,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_release,
    output logic [7:0]    rd_data,
    output logic          frm_valid,
    output logic          frm_done,
    output logic [AW:0]   frm_len,
    output logic          frm_ovf,
    output logic          frm_odd,
    output logic [7:0]    drop_cnt,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, HUNT, DATA, DISCARD, DONE} state_t;

    state_t        state, state_d;
    logic          wr_bank, rd_bank;
    logic [AW:0]   wr_ptr;
    logic          ovf, odd, seen5, half;
    logic [3:0]    nib_lo;
    logic          nib_cap, wr_en, held, accept, drop;
    logic [7:0]    mem [0:2*DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (rx_dv) state_d = (STRIP_PRE != 0) ? HUNT : DATA;
            HUNT: begin
                if (!rx_dv)                     state_d = IDLE;
                else if (rx_d == 4'h5)          state_d = HUNT;
                else if (rx_d == 4'hD && seen5) state_d = DATA;
                else                            state_d = DISCARD;
            end
            DATA:    if (!rx_dv) state_d = DONE;
            DISCARD: if (!rx_dv) state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign nib_cap = rx_dv && ((state == DATA) || (state == IDLE && STRIP_PRE == 0));
    // wr_ptr saturates at DEPTH, so its MSB alone marks a full bank
    assign wr_en   = nib_cap && half && !wr_ptr[AW];
    // a release in the same cycle as DONE frees the read bank for this frame
    assign held    = frm_valid && !rd_release;
    assign accept  = (state == DONE) && (wr_ptr != '0) && !held;
    assign drop    = (state == DONE) && (wr_ptr != '0) && held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            ovf       <= 1'b0;
            odd       <= 1'b0;
            seen5     <= 1'b0;
            half      <= 1'b0;
            nib_lo    <= 4'h0;
        end else if (state_d == IDLE) begin
            wr_ptr    <= '0;
            ovf       <= 1'b0;
            odd       <= 1'b0;
            seen5     <= 1'b0;
            half      <= 1'b0;
        end else begin
            if (state == IDLE)                    seen5 <= (rx_d == 4'h5);
            if (state == HUNT && rx_d == 4'h5)    seen5 <= 1'b1;
            if (nib_cap) begin
                if (!half) begin
                    nib_lo <= rx_d;
                    half   <= 1'b1;
                end else begin
                    half <= 1'b0;
                    if (wr_ptr[AW]) ovf    <= 1'b1;
                    else            wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (state == DATA && !rx_dv) begin
                odd  <= half;
                half <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b1;
            frm_valid <= 1'b0;
            frm_done  <= 1'b0;
            frm_len   <= '0;
            frm_ovf   <= 1'b0;
            frm_odd   <= 1'b0;
            drop_cnt  <= 8'h00;
            rd_data   <= 8'h00;
        end else begin
            frm_done <= accept;
            if (accept) begin
                rd_bank   <= wr_bank;
                wr_bank   <= ~wr_bank;
                frm_valid <= 1'b1;
                frm_len   <= wr_ptr;
                frm_ovf   <= ovf;
                frm_odd   <= odd;
            end else if (rd_release) begin
                frm_valid <= 1'b0;
            end
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            rd_data <= (frm_valid && ({1'b0, rd_addr} < frm_len)) ? mem[{rd_bank, rd_addr}] : 8'h00;
        end
    end

    // frame storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_ptr[AW-1:0]}] <= {rx_d, nib_lo};
    end

endmodule

// File: tb/tb_mii_rx_frame_buf.sv
// Bench for mii_rx_frame_buf: table of frames with a scoreboard of expected
// frame descriptors, plus drop / bad-preamble / reset / raw-capture sequences.
module tb_mii_rx_frame_buf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0, rd_release = 1'b0;
    logic [3:0] rx_d = 4'h0;
    logic [5:0] rd_addr = 6'd0;
    logic [7:0] rd_data, drop_cnt;
    logic       frm_valid, frm_done, frm_ovf, frm_odd, busy;
    logic [6:0] frm_len;

    logic       raw_dv = 1'b0, raw_rel = 1'b0;
    logic [3:0] raw_d = 4'h0;
    logic [5:0] raw_addr = 6'd0;
    logic [7:0] raw_data, raw_drop;
    logic       raw_valid, raw_done, raw_ovf, raw_odd, raw_busy;
    logic [6:0] raw_len;

    always #5 clk = ~clk;

    mii_rx_frame_buf #(.DEPTH(64), .AW(6), .STRIP_PRE(1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_d(rx_d), .rd_addr(rd_addr),
        .rd_release(rd_release), .rd_data(rd_data), .frm_valid(frm_valid),
        .frm_done(frm_done), .frm_len(frm_len), .frm_ovf(frm_ovf), .frm_odd(frm_odd),
        .drop_cnt(drop_cnt), .busy(busy));

    mii_rx_frame_buf #(.DEPTH(64), .AW(6), .STRIP_PRE(0)) u_raw (
        .clk(clk), .rst_n(rst_n), .rx_dv(raw_dv), .rx_d(raw_d), .rd_addr(raw_addr),
        .rd_release(raw_rel), .rd_data(raw_data), .frm_valid(raw_valid),
        .frm_done(raw_done), .frm_len(raw_len), .frm_ovf(raw_ovf), .frm_odd(raw_odd),
        .drop_cnt(raw_drop), .busy(raw_busy));

    typedef struct { int len; bit ovf; bit odd; } exp_t;
    typedef struct {
        int nbytes; logic [7:0] base; bit oddn;
        int len; bit ovf; bit odd; int addr; logic [7:0] data;
    } vec_t;

    exp_t sb[$];
    int   nchk = 0, nerr = 0, done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every accepted frame must match the oldest pushed descriptor
    always @(negedge clk) begin
        if (frm_done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_len", frm_len, e.len);
                chk("sb_ovf", frm_ovf, e.ovf);
                chk("sb_odd", frm_odd, e.odd);
                chk("sb_valid_aligned", frm_valid, 1);
            end
        end
    end

    task automatic nib(input logic dv, input logic [3:0] d);
        @(posedge clk); #1;
        rx_dv = dv; rx_d = d;
    endtask

    task automatic raw_nib(input logic dv, input logic [3:0] d);
        @(posedge clk); #1;
        raw_dv = dv; raw_d = d;
    endtask

    task automatic pulse_release();
        @(posedge clk); #1 rd_release = 1'b1;
        @(posedge clk); #1 rd_release = 1'b0;
    endtask

    task automatic send_frame(input int nbytes, input logic [7:0] base, input bit oddn, input bit rel);
        logic [7:0] b;
        for (int i = 0; i < 7; i++) nib(1'b1, 4'h5);
        nib(1'b1, 4'hD);
        for (int i = 0; i < nbytes; i++) begin
            b = base + 8'(i);
            nib(1'b1, b[3:0]);
            nib(1'b1, b[7:4]);
        end
        if (oddn) nib(1'b1, 4'h7);
        nib(1'b0, 4'h0);
        // land the release on the single DONE cycle
        if (rel) pulse_release();
    endtask

    task automatic wait_done(input string name);
        int s;
        bit ok;
        s = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (done_cnt != s) begin ok = 1'b1; break; end
        end
        chk(name, ok, 1);
    endtask

    task automatic read_chk(input string name, input int addr, input logic [7:0] exp);
        @(posedge clk); #1 rd_addr = 6'(addr);
        @(posedge clk);
        @(negedge clk);
        chk(name, rd_data, exp);
    endtask

    vec_t vt[6];

    initial begin
        int s;
        bit ok;
        vt[0] = '{nbytes: 10, base: 8'h00, oddn: 0, len: 10, ovf: 0, odd: 0, addr: 3,  data: 8'h03};
        vt[1] = '{nbytes: 70, base: 8'h00, oddn: 0, len: 64, ovf: 1, odd: 0, addr: 63, data: 8'h3F};
        vt[2] = '{nbytes: 1,  base: 8'hA5, oddn: 0, len: 1,  ovf: 0, odd: 0, addr: 0,  data: 8'hA5};
        vt[3] = '{nbytes: 3,  base: 8'h10, oddn: 1, len: 3,  ovf: 0, odd: 1, addr: 2,  data: 8'h12};
        vt[4] = '{nbytes: 64, base: 8'h80, oddn: 0, len: 64, ovf: 0, odd: 0, addr: 63, data: 8'hBF};
        vt[5] = '{nbytes: 4,  base: 8'h20, oddn: 0, len: 4,  ovf: 0, odd: 0, addr: 5,  data: 8'h00};

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", frm_valid, 0);
        chk("rst_len", frm_len, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_rd_data", rd_data, 0);
        #20 rst_n = 1'b1;
        read_chk("rd_before_first_frame", 0, 8'h00);

        for (int v = 0; v < 6; v++) begin
            sb.push_back('{len: vt[v].len, ovf: vt[v].ovf, odd: vt[v].odd});
            send_frame(vt[v].nbytes, vt[v].base, vt[v].oddn, 1'b0);
            wait_done($sformatf("vec%0d_done", v));
            chk($sformatf("vec%0d_valid", v), frm_valid, 1);
            read_chk($sformatf("vec%0d_data", v), vt[v].addr, vt[v].data);
            pulse_release();
            @(negedge clk);
            chk($sformatf("vec%0d_released", v), frm_valid, 0);
            read_chk($sformatf("vec%0d_data_after_rel", v), vt[v].addr, 8'h00);
        end

        // second frame while first is held is dropped; third accepted via release at DONE
        sb.push_back('{len: 5, ovf: 0, odd: 0});
        send_frame(5, 8'h40, 1'b0, 1'b0);
        wait_done("drop_first_done");
        s = done_cnt;
        send_frame(6, 8'h50, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        chk("drop_no_done", done_cnt - s, 0);
        chk("drop_cnt_1", drop_cnt, 1);
        chk("drop_len_kept", frm_len, 5);
        read_chk("drop_data_kept", 0, 8'h40);
        sb.push_back('{len: 7, ovf: 0, odd: 0});
        send_frame(7, 8'h60, 1'b0, 1'b1);
        wait_done("rel_at_done_accept");
        chk("rel_at_done_drop_cnt", drop_cnt, 1);
        read_chk("rel_at_done_data", 6, 8'h66);

        // bad preamble goes to DISCARD and produces nothing
        s = done_cnt;
        nib(1'b1, 4'h5); nib(1'b1, 4'h5); nib(1'b1, 4'hA); nib(1'b1, 4'hA); nib(1'b1, 4'h3);
        nib(1'b0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("badpre_idle", busy, 0);
        chk("badpre_no_done", done_cnt - s, 0);
        chk("badpre_drop_cnt", drop_cnt, 1);
        chk("badpre_valid_kept", frm_valid, 1);

        // asynchronous reset in the middle of a frame
        for (int i = 0; i < 7; i++) nib(1'b1, 4'h5);
        nib(1'b1, 4'hD);
        nib(1'b1, 4'h1); nib(1'b1, 4'h2); nib(1'b1, 4'h3);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", frm_valid, 0);
        chk("midrst_len", frm_len, 0);
        chk("midrst_drop", drop_cnt, 0);
        chk("midrst_rd_data", rd_data, 0);
        rx_dv = 1'b0;
        #12 rst_n = 1'b1;
        sb.push_back('{len: 8, ovf: 0, odd: 0});
        send_frame(8, 8'h70, 1'b0, 1'b0);
        wait_done("postrst_done");
        read_chk("postrst_data", 7, 8'h77);
        pulse_release();

        // raw capture: five nibbles give two bytes and an odd leftover
        raw_nib(1'b1, 4'h1); raw_nib(1'b1, 4'h2); raw_nib(1'b1, 4'h3);
        raw_nib(1'b1, 4'h4); raw_nib(1'b1, 4'h5); raw_nib(1'b0, 4'h0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (raw_done) begin ok = 1'b1; break; end
        end
        chk("raw_done", ok, 1);
        chk("raw_len", raw_len, 2);
        chk("raw_odd", raw_odd, 1);
        chk("raw_ovf", raw_ovf, 0);
        @(posedge clk); #1 raw_addr = 6'd1;
        @(posedge clk);
        @(negedge clk);
        chk("raw_data", raw_data, 8'h43);

        repeat (4) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
